// File: rtl/regfile_dump_reader.sv
// Streams regfile entries FIRST_REG..LAST_REG out of a spare async read port as idx-tagged beats.
// Two cycles per register minimum; SEND holds the beat stable until out_ready, abort cancels at any time.
module regfile_dump_reader #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [ADDR_W-1:0]  out_idx_q, out_idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= FIRST_IDX;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = READ;
          idx_d   = FIRST_IDX;
        end
      end
      READ: begin
        if (abort) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          idx_d       = FIRST_IDX;
        end else begin
          out_data_d  = rd_data;
          out_idx_d   = idx_q;
          out_valid_d = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        // A beat handshaking alongside abort is still delivered; only the walk stops.
        if (abort) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          idx_d       = FIRST_IDX;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = READ;
          end
        end
      end
      DONE: begin
        idx_d   = FIRST_IDX;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_addr = idx_q;
    busy    = (state_q == READ) || (state_q == SEND);
    done    = (state_q == DONE);
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: behavioural regfile array, expected-beat queues, negedge monitors.
module tb_regfile_dump_reader;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, start, abort, out_ready;
  logic [4:0]  rd_addr, out_idx;
  logic [31:0] rd_data, out_data;
  logic        out_valid, busy, done;

  logic        start2, abort2, ready2;
  logic [4:0]  rd_addr2, out_idx2;
  logic [31:0] rd_data2, out_data2;
  logic        out_valid2, busy2, done2;

  logic [31:0] regs [32];
  beat_t       exp_q[$];
  beat_t       exp_q2[$];

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int beats2 = 0;

  logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_done = 1'b0;
  logic [31:0] prev_data = '0;
  logic [4:0]  prev_idx = '0;

  always #5 clk = ~clk;

  assign rd_data  = regs[rd_addr];
  assign rd_data2 = regs[rd_addr2];

  regfile_dump_reader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx),
    .busy(busy), .done(done)
  );

  regfile_dump_reader #(.FIRST_REG(10), .LAST_REG(10)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2),
    .rd_addr(rd_addr2), .rd_data(rd_data2),
    .out_valid(out_valid2), .out_ready(ready2),
    .out_data(out_data2), .out_idx(out_idx2),
    .busy(busy2), .done(done2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Beats are popped on the negedge before the handshaking posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_unexpected: got idx %0d data %0h want none", out_idx, out_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_idx", 64'(out_idx), 64'(e.idx));
          check("beat_data", 64'(out_data), 64'(e.data));
        end
      end
      if (prev_valid && !prev_ready && out_valid) begin
        check("hold_data", 64'(out_data), 64'(prev_data));
        check("hold_idx", 64'(out_idx), 64'(prev_idx));
      end
      if (done) begin
        done_cnt++;
        check("done_single", 64'(prev_done), 64'(0));
      end
    end
    prev_valid <= out_valid;
    prev_ready <= out_ready;
    prev_data  <= out_data;
    prev_idx   <= out_idx;
    prev_done  <= done;
  end

  always @(negedge clk) begin
    if (!rst && out_valid2 && ready2) begin
      beats2++;
      if (exp_q2.size() == 0) begin
        total++;
        bad++;
        $display("FAIL beat2_unexpected: got idx %0d data %0h want none", out_idx2, out_data2);
      end else begin
        beat_t e;
        e = exp_q2.pop_front();
        check("beat2_idx", 64'(out_idx2), 64'(e.idx));
        check("beat2_data", 64'(out_data2), 64'(e.data));
      end
    end
  end

  task automatic preload_seq();
    for (int a = 0; a < 32; a++) regs[a] = (a == 0) ? 32'h0 : 32'h100 + 32'(a);
  endtask

  task automatic preload_rand();
    for (int a = 0; a < 32; a++) regs[a] = $urandom;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) exp_q.push_back('{5'(a), regs[a]});
  endtask

  // mode 0: ready held high, 1: ready toggles 1/0, 2: random ready.
  task automatic run_dump(input int mode, output int cyc_done, output int cyc_valid);
    cyc_done  = 0;
    cyc_valid = 0;
    push_range(0, 31);
    start     = 1'b1;
    out_ready = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = n[0];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && cyc_valid == 0) cyc_valid = n;
      if (done) begin
        cyc_done = n;
        break;
      end
    end
    check("dump_finished", 64'(cyc_done != 0), 64'(1));
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cd, cv, snap, n;
    logic hit, wr;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    start2 = 1'b0; abort2 = 1'b0; ready2 = 1'b1;
    preload_seq();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_data", 64'(out_data), 64'(0));
    check("rst_idx", 64'(out_idx), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rd_addr", 64'(rd_addr), 64'(0));

    // Sequential preload, ready held high: timing of first valid and done.
    run_dump(0, cd, cv);
    check("first_valid_cycle", 64'(cv), 64'(2));
    check("done_cycle", 64'(cd), 64'(65));

    run_dump(1, cd, cv);
    preload_rand();
    run_dump(2, cd, cv);
    preload_rand();
    run_dump(2, cd, cv);

    // Abort in SEND of idx 5 with ready low.
    preload_seq();
    push_range(0, 4);
    snap = done_cnt;
    start = 1'b1; out_ready = 1'b1; hit = 1'b0;
    for (n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (out_valid && out_idx == 5'd4) begin
        hit = 1'b1;
        break;
      end
    end
    check("abort_reach_beat4", 64'(hit), 64'(1));
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("abort_pre_valid", 64'(out_valid), 64'(1));
    check("abort_pre_idx", 64'(out_idx), 64'(5));
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_valid", 64'(out_valid), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_rd_addr", 64'(rd_addr), 64'(0));
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt - snap), 64'(0));
    check("abort_queue", 64'(exp_q.size()), 64'(0));
    run_dump(0, cd, cv);
    check("restart_done_cycle", 64'(cd), 64'(65));

    // start re-pulsed at beat 3, reset at beat 7.
    push_range(0, 7);
    snap = done_cnt;
    start = 1'b1; out_ready = 1'b1; hit = 1'b0;
    for (n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (out_valid && out_idx == 5'd3) start = 1'b1;
      if (out_valid && out_idx == 5'd7) begin
        hit = 1'b1;
        break;
      end
    end
    check("rst_reach_beat7", 64'(hit), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_valid", 64'(out_valid), 64'(0));
    check("midrst_data", 64'(out_data), 64'(0));
    check("midrst_idx", 64'(out_idx), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_rd_addr", 64'(rd_addr), 64'(0));
    repeat (80) @(posedge clk);
    #1;
    check("midrst_queue", 64'(exp_q.size()), 64'(0));
    check("midrst_no_done", 64'(done_cnt - snap), 64'(0));
    check("midrst_idle", 64'(busy), 64'(0));

    // Write to x4 during its READ cycle is not seen.
    preload_seq();
    push_range(0, 31);
    start = 1'b1; out_ready = 1'b1; wr = 1'b0; hit = 1'b0;
    for (n = 0; n < 200; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        hit = 1'b1;
        break;
      end
      if (busy && !out_valid && rd_addr == 5'd4 && !wr) begin
        wr = 1'b1;
        @(posedge clk);
        regs[4] <= 32'h55;
        #1;
        if (done) begin
          hit = 1'b1;
          break;
        end
      end
    end
    check("wr_write_issued", 64'(wr), 64'(1));
    check("wr_done", 64'(hit), 64'(1));
    check("wr_queue", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;

    // Single-register dump on the FIRST_REG=LAST_REG=10 instance.
    regs[10] = 32'hDEADBEEF;
    exp_q2.push_back('{5'd10, 32'hDEADBEEF});
    start2 = 1'b1; cd = 0;
    for (n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      start2 = 1'b0;
      if (done2) begin
        cd = n;
        break;
      end
    end
    check("single_done_cycle", 64'(cd), 64'(3));
    check("single_beats", 64'(beats2), 64'(1));
    check("single_queue", 64'(exp_q2.size()), 64'(0));

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
